// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cnn_pkg                                                         |
// | Purpose  : Shared types and helpers for the convolution MAC stream:        |
// |            activation-mode enum, accumulator width function and a          |
// |            generic sign-extension helper.                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cnn_pkg;

  typedef enum logic [1:0] {
    ACT_RELU   = 2'd0,
    ACT_SIGNUM = 2'd1,
    ACT_CLIP   = 2'd2,
    ACT_RSVD   = 2'd3
  } act_mode_e;

  // Product width, plus growth for KERNEL_SIZE*IN_CH terms, plus one sign
  // bit of headroom for the bias.
  function automatic int acc_width(input int dw, input int kw, input int ks, input int ic);
    return dw + kw + 1 + $clog2(ks * ic) + 1;
  endfunction

  // Sign-extend the low 'width' bits of val to 64 bits.
  function automatic logic [63:0] sign_extend(input logic [63:0] val, input int width);
    return $signed(val << (64 - width)) >>> (64 - width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_act_sat.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_act_sat                                                    |
// | Purpose  : Combinational fixed-point rescale, activation, clip and         |
// |            saturation of one accumulated output pixel.                     |
// | Ports    : acc     in  signed accumulator value (Q.(KDATA_WIDTH-1))        |
// |            mode    in  activation mode                                     |
// |            feature out activated pixel                                     |
// |            sat     out pixel was clipped at the top of the output range    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module conv_act_sat
  import cnn_pkg::*;
#(
  parameter int ACC_W       = 24,
  parameter int DATA_WIDTH  = 8,
  parameter int KDATA_WIDTH = 8,
  parameter int CLIP_MAX    = 6
) (
  input  logic signed [ACC_W-1:0]      acc,
  input  act_mode_e                    mode,
  output logic        [DATA_WIDTH-1:0] feature,
  output logic                         sat
);

  localparam logic signed [ACC_W-1:0] c_pix_max  = ACC_W'((1 << DATA_WIDTH) - 1);
  localparam logic signed [ACC_W-1:0] c_clip_max = ACC_W'(CLIP_MAX);

  // Drop the kernel's fractional bits; arithmetic shift rounds toward -inf.
  logic signed [ACC_W-1:0] w_v;
  logic                    w_neg;

  assign w_v   = acc >>> (KDATA_WIDTH - 1);
  assign w_neg = w_v[ACC_W-1];

  always_comb begin
    feature = '0;
    sat     = 1'b0;
    case (mode)
      ACT_RELU: begin
        if (w_neg) begin
          feature = '0;
        end else if (w_v > c_pix_max) begin
          feature = '1;
          sat     = 1'b1;
        end else begin
          feature = w_v[DATA_WIDTH-1:0];
        end
      end
      ACT_SIGNUM: begin
        feature = w_neg ? '0 : '1;
      end
      ACT_CLIP: begin
        if (w_neg) begin
          feature = '0;
        end else if (w_v > c_clip_max) begin
          feature = c_clip_max[DATA_WIDTH-1:0];
        end else begin
          feature = w_v[DATA_WIDTH-1:0];
        end
      end
      default: begin
        feature = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/conv_mac_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : conv_mac_stream                                                 |
// | Purpose  : Multi-channel streaming convolution MAC. Each accepted beat     |
// |            carries one channel's window and kernel; IN_CH beats are        |
// |            accumulated with a bias into one activated output pixel.        |
// | Ports    : clk, rst (async, active-low)                                    |
// |            in_valid/in_ready     input beat handshake                      |
// |            image, kernel         window pixels and signed weights          |
// |            bias, act_mode        sampled on the first beat of a pixel      |
// |            out_valid/out_ready   output pixel handshake                    |
// |            feature, out_sat      activated pixel and saturation flag       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module conv_mac_stream
  import cnn_pkg::*;
#(
  parameter int KERNEL_SIZE = 9,
  parameter int IN_CH       = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KDATA_WIDTH = 8,
  parameter int BIAS_WIDTH  = 16,
  parameter int CLIP_MAX    = 6
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0]  image,
  input  logic [KERNEL_SIZE-1:0][KDATA_WIDTH-1:0] kernel,
  input  logic signed [BIAS_WIDTH-1:0]            bias,
  input  logic [1:0]                              act_mode,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [DATA_WIDTH-1:0]                   feature,
  output logic                                    out_sat
);

  localparam int c_prod_w = DATA_WIDTH + KDATA_WIDTH + 1;
  localparam int c_acc_w  = acc_width(DATA_WIDTH, KDATA_WIDTH, KERNEL_SIZE, IN_CH);
  localparam int c_cnt_w  = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam logic [c_cnt_w-1:0] c_last_ch = c_cnt_w'(IN_CH - 1);

  logic                        w_stall;
  logic                        w_first;
  logic                        w_last;
  logic [c_cnt_w-1:0]          r_ch_cnt;

  // Stage 1: per-tap products
  logic signed [c_prod_w-1:0]  r_prod [KERNEL_SIZE];
  logic                        r_s1_valid;
  logic                        r_s1_first;
  logic                        r_s1_last;
  logic signed [BIAS_WIDTH-1:0] r_s1_bias;
  act_mode_e                   r_s1_mode;

  // Stage 2: registered tap sum
  logic signed [c_acc_w-1:0]   w_sum;
  logic signed [c_acc_w-1:0]   r_s2_sum;
  logic                        r_s2_valid;
  logic                        r_s2_first;
  logic                        r_s2_last;
  logic signed [BIAS_WIDTH-1:0] r_s2_bias;
  act_mode_e                   r_s2_mode;

  // Stage 3: accumulate and activate
  logic signed [c_acc_w-1:0]   r_acc;
  logic signed [c_acc_w-1:0]   w_bias_ext;
  logic signed [c_acc_w-1:0]   w_acc_next;
  logic [DATA_WIDTH-1:0]       w_act_feature;
  logic                        w_act_sat;

  // The whole pipe freezes while a result waits, so no beat can be lost
  // and no skid buffer is needed.
  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;
  assign w_first  = (r_ch_cnt == '0);
  assign w_last   = (r_ch_cnt == c_last_ch);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ch_cnt   <= '0;
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_bias  <= '0;
      r_s1_mode  <= ACT_RELU;
      for (int i = 0; i < KERNEL_SIZE; i++) begin
        r_prod[i] <= '0;
      end
    end else if (!w_stall) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_first <= w_first;
        r_s1_last  <= w_last;
        r_ch_cnt   <= w_last ? '0 : r_ch_cnt + 1'b1;
        // Bias and mode are held from the first beat so the last beat of
        // the same pixel still sees them when it reaches the activation.
        if (w_first) begin
          r_s1_bias <= bias;
          r_s1_mode <= act_mode_e'(act_mode);
        end
        for (int i = 0; i < KERNEL_SIZE; i++) begin
          r_prod[i] <= c_prod_w'($signed({1'b0, image[i]})) * c_prod_w'($signed(kernel[i]));
        end
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      w_sum = w_sum + {{(c_acc_w - c_prod_w){r_prod[i][c_prod_w-1]}}, r_prod[i]};
    end
  end

  // The tap sum is registered ahead of the accumulator, which keeps the
  // adder and activation paths apart: last beat accepted at edge t gives
  // out_valid at edge t+2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_bias  <= '0;
      r_s2_mode  <= ACT_RELU;
    end else if (!w_stall) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sum   <= w_sum;
        r_s2_first <= r_s1_first;
        r_s2_last  <= r_s1_last;
        r_s2_bias  <= r_s1_bias;
        r_s2_mode  <= r_s1_mode;
      end
    end
  end

  assign w_bias_ext = c_acc_w'(sign_extend(64'(r_s2_bias), BIAS_WIDTH));
  assign w_acc_next = (r_s2_first ? w_bias_ext : r_acc) + r_s2_sum;

  conv_act_sat #(
    .ACC_W       (c_acc_w),
    .DATA_WIDTH  (DATA_WIDTH),
    .KDATA_WIDTH (KDATA_WIDTH),
    .CLIP_MAX    (CLIP_MAX)
  ) u_act (
    .acc     (w_acc_next),
    .mode    (r_s2_mode),
    .feature (w_act_feature),
    .sat     (w_act_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      out_valid <= 1'b0;
      feature   <= '0;
      out_sat   <= 1'b0;
    end else if (!w_stall) begin
      if (r_s2_valid) begin
        r_acc <= w_acc_next;
      end
      // Not stalled means any pending result is being taken this edge, so
      // out_valid only survives if a new pixel completes right now.
      if (r_s2_valid && r_s2_last) begin
        out_valid <= 1'b1;
        feature   <= w_act_feature;
        out_sat   <= w_act_sat;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_stream.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_conv_mac_stream                                              |
// | Purpose  : Self-checking bench for conv_mac_stream (IN_CH=4 and IN_CH=1    |
// |            instances) against an arithmetic reference model.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_conv_mac_stream;

  localparam int KS  = 9;
  localparam int NCH = 4;
  typedef logic [KS-1:0][7:0] win_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_valid1 = 1'b0;
  logic               out_ready = 1'b1;
  win_t               image = '0;
  win_t               kernel = '0;
  logic signed [15:0] bias = '0;
  logic [1:0]         act_mode = '0;
  logic               in_ready, in_ready1, out_valid, out_valid1, out_sat, out_sat1;
  logic [7:0]         feature, feature1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] got_q[$];
  logic [8:0] got1_q[$];
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  conv_mac_stream #(.IN_CH(NCH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .image(image), .kernel(kernel), .bias(bias), .act_mode(act_mode),
    .out_valid(out_valid), .out_ready(out_ready), .feature(feature), .out_sat(out_sat)
  );

  conv_mac_stream #(.IN_CH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .image(image), .kernel(kernel), .bias(bias), .act_mode(act_mode),
    .out_valid(out_valid1), .out_ready(out_ready), .feature(feature1), .out_sat(out_sat1)
  );

  // Outputs are stable between negedge and the next posedge; a handshake
  // seen here completes on the following posedge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready)  got_q.push_back({out_sat, feature});
    if (rst && out_valid1 && out_ready) got1_q.push_back({out_sat1, feature1});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d tests run", n_tests);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int dot(input win_t im, input win_t k);
    int s = 0;
    for (int i = 0; i < KS; i++) s += int'(im[i]) * int'($signed(k[i]));
    return s;
  endfunction

  function automatic logic [8:0] ref_pixel(input int total, input logic [1:0] mode);
    int v;
    v = total >>> 7;
    case (mode)
      2'd0: begin
        if (v < 0) return 9'h000;
        if (v > 255) return 9'h1FF;
        return {1'b0, v[7:0]};
      end
      2'd1: return (v < 0) ? 9'h000 : 9'h0FF;
      2'd2: begin
        if (v < 0) return 9'h000;
        if (v > 6) return 9'h006;
        return {1'b0, v[7:0]};
      end
      default: return 9'h000;
    endcase
  endfunction

  function automatic win_t fill(input logic [7:0] v);
    win_t w;
    for (int i = 0; i < KS; i++) w[i] = v;
    return w;
  endfunction

  function automatic win_t rand_win(input int lo, input int hi);
    win_t w;
    for (int i = 0; i < KS; i++) w[i] = 8'(int'($urandom_range(0, hi - lo)) + lo);
    return w;
  endfunction

  function automatic logic signed [15:0] rand_bias();
    return 16'(int'($urandom_range(0, 8000)) - 4000);
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send_beat(input win_t im, input win_t k, input logic signed [15:0] b,
                           input logic [1:0] m);
    bit acc;
    image = im; kernel = k; bias = b; act_mode = m; in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    n_tests++; n_fail++;
    $display("FAIL send_beat: beat not accepted in 200 cycles, in_ready=%0b required 1", in_ready);
  endtask

  // Non-first beats carry random bias/mode, which the DUT must ignore.
  task automatic send_pixel(input win_t ims[NCH], input win_t ks[NCH],
                            input logic signed [15:0] b, input logic [1:0] m);
    int total;
    total = int'(b);
    for (int c = 0; c < NCH; c++) total += dot(ims[c], ks[c]);
    exp_q.push_back(ref_pixel(total, m));
    for (int c = 0; c < NCH; c++) begin
      if (c == 0) send_beat(ims[c], ks[c], b, m);
      else        send_beat(ims[c], ks[c], 16'($urandom), 2'($urandom));
    end
  endtask

  task automatic drain(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (got_q.size() >= n) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_tests++; if (feature !== 8'h00) begin n_fail++; $display("FAIL reset_feature: got %h required 00", feature); end
    n_tests++; if (out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_out_sat: got %b required 0", out_sat); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid1: got %b required 0", out_valid1); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_channel();
    logic [8:0] exp1[$];
    win_t im, k;
    logic signed [15:0] b;
    logic [1:0] m;
    image = fill(8'd10); kernel = fill(8'h40); bias = '0; act_mode = 2'd0; in_valid1 = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL ch1_in_ready: got %b required 1", in_ready1); end
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL ch1_lat_t0: out_valid got %b required 0", out_valid1); end
    @(negedge clk);
    n_tests++; if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL ch1_lat_t1: out_valid got %b required 0", out_valid1); end
    @(negedge clk);
    n_tests++; if (out_valid1 !== 1'b1) begin n_fail++; $display("FAIL ch1_lat_t2: out_valid got %b required 1", out_valid1); end
    n_tests++; if (feature1 !== 8'd45) begin n_fail++; $display("FAIL ch1_feature: got %0d required 45", feature1); end
    n_tests++; if (out_sat1 !== 1'b0) begin n_fail++; $display("FAIL ch1_out_sat: got %b required 0", out_sat1); end
    @(posedge clk); #1;
    got1_q.delete();
    for (int p = 0; p < 8; p++) begin
      im = rand_win(0, 255); k = rand_win(-24, 24); b = rand_bias(); m = 2'($urandom_range(0, 3));
      exp1.push_back(ref_pixel(int'(b) + dot(im, k), m));
      image = im; kernel = k; bias = b; act_mode = m; in_valid1 = 1'b1;
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_tests++;
    if (got1_q.size() != exp1.size()) begin
      n_fail++; $display("FAIL ch1_b2b_count: got %0d outputs required %0d", got1_q.size(), exp1.size());
    end
    for (int i = 0; i < exp1.size() && i < got1_q.size(); i++) begin
      n_tests++;
      if (got1_q[i] !== exp1[i]) begin
        n_fail++; $display("FAIL ch1_b2b[%0d]: got sat/feature %h required %h", i, got1_q[i], exp1[i]);
      end
    end
    got1_q.delete();
  endtask

  task automatic test_saturation();
    bit ok;
    for (int c = 0; c < NCH; c++) send_beat(fill(8'd100), fill(8'h7F), 16'sd0, 2'd0);
    in_valid = 1'b0;
    drain(1, ok);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL sat_count: got %0d outputs required 1", got_q.size()); end
    n_tests++;
    if (got_q.size() < 1 || got_q[0] !== 9'h1FF) begin
      n_fail++; $display("FAIL sat_value: got %h required 1ff", (got_q.size() > 0) ? got_q[0] : 9'hxxx);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_signum();
    bit ok;
    for (int c = 0; c < NCH; c++) send_beat(fill(8'd5), fill(8'h80), 16'sd0, 2'd1);
    for (int c = 0; c < NCH; c++) send_beat(fill(8'd5), fill(8'h00), 16'sd0, 2'd1);
    in_valid = 1'b0;
    drain(2, ok);
    n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL signum_count: got %0d outputs required 2", got_q.size()); end
    n_tests++; if (got_q.size() < 1 || got_q[0] !== 9'h000) begin n_fail++; $display("FAIL signum_neg: got %h required 000", (got_q.size() > 0) ? got_q[0] : 9'hxxx); end
    n_tests++; if (got_q.size() < 2 || got_q[1] !== 9'h0FF) begin n_fail++; $display("FAIL signum_zero: got %h required 0ff", (got_q.size() > 1) ? got_q[1] : 9'hxxx); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_clip();
    win_t ims[NCH], ks[NCH];
    bit ok;
    for (int c = 0; c < NCH; c++) begin ims[c] = fill(8'd0); ks[c] = fill(8'h40); end
    ims[0] = fill(8'd3);
    send_pixel(ims, ks, 16'sd0, 2'd2);             // v=13 -> 6
    send_pixel(ims, ks, -16'sd1664, 2'd2);         // v=0  -> 0
    ims[0] = fill(8'd1);
    send_pixel(ims, ks, 16'sd0, 2'd2);             // v=4  -> 4
    in_valid = 1'b0;
    drain(3, ok);
    n_tests++; if (got_q.size() != 3) begin n_fail++; $display("FAIL clip_count: got %0d outputs required 3", got_q.size()); end
    n_tests++; if (got_q.size() < 1 || got_q[0] !== 9'h006) begin n_fail++; $display("FAIL clip_high: got %h required 006", (got_q.size() > 0) ? got_q[0] : 9'hxxx); end
    n_tests++; if (got_q.size() < 2 || got_q[1] !== 9'h000) begin n_fail++; $display("FAIL clip_bias: got %h required 000", (got_q.size() > 1) ? got_q[1] : 9'hxxx); end
    n_tests++; if (got_q.size() < 3 || got_q[2] !== 9'h004) begin n_fail++; $display("FAIL clip_pass: got %h required 004", (got_q.size() > 2) ? got_q[2] : 9'hxxx); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    win_t ims[NCH], ks[NCH];
    bit ok;
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < NCH; c++) begin ims[c] = rand_win(0, 255); ks[c] = rand_win(-20, 20); end
      send_pixel(ims, ks, rand_bias(), 2'($urandom_range(0, 3)));
    end
    in_valid = 1'b0;
    drain(exp_q.size(), ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d outputs required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b[%0d]: got sat/feature %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    win_t ims[NCH], ks[NCH];
    logic [8:0] held;
    bit ok, seen;
    fork
      begin
        for (int p = 0; p < 4; p++) begin
          for (int c = 0; c < NCH; c++) begin ims[c] = rand_win(0, 255); ks[c] = rand_win(-16, 16); end
          send_pixel(ims, ks, rand_bias(), 2'($urandom_range(0, 2)));
        end
        in_valid = 1'b0;
      end
      begin
        out_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
          @(negedge clk);
          seen = out_valid;
        end
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL bp_first_out: out_valid got 0 required 1 within 50 cycles"); end
        held = {out_sat, feature};
        for (int c = 0; c < 5; c++) begin
          if (c > 0) @(negedge clk);
          n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b required 0", c, in_ready); end
          n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid[%0d]: got %b required 1", c, out_valid); end
          n_tests++; if ({out_sat, feature} !== held) begin n_fail++; $display("FAIL bp_stable[%0d]: got %h required %h", c, {out_sat, feature}, held); end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain(exp_q.size(), ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d outputs required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp[%0d]: got sat/feature %h required %h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midpixel();
    win_t ims[NCH], ks[NCH];
    bit ok;
    send_beat(fill(8'd200), fill(8'h7F), 16'sd0, 2'd0);
    send_beat(fill(8'd200), fill(8'h7F), 16'sd0, 2'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid[%0d]: got %b required 0", c, out_valid); end
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < NCH; c++) begin ims[c] = fill(8'd20); ks[c] = fill(8'h10); end
    send_pixel(ims, ks, 16'sd0, 2'd0);
    in_valid = 1'b0;
    drain(1, ok);
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d outputs required 1", got_q.size()); end
    n_tests++; if (got_q.size() < 1 || got_q[0] !== 9'h05A) begin n_fail++; $display("FAIL rstmid_value: got %h required 05a", (got_q.size() > 0) ? got_q[0] : 9'hxxx); end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_saturation();
    test_signum();
    test_clip();
    test_back_to_back();
    test_backpressure();
    test_reset_midpixel();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
